// File: rtl/dbus_store_arbiter_pkg.sv
// rtl/dbus_store_arbiter_pkg.sv - shared request types and defaults for the dbus store arbiter
package dbus_store_arbiter_pkg;

    typedef struct packed {
        logic        read;
        logic        write;
        logic        uncached;
        logic [3:0]  byteenable;
        logic [31:0] paddr;
        logic [31:0] wrdata;
    } data_memreq_t;

    typedef data_memreq_t sb_entry_t;

    localparam int SB_DEPTH_DEFAULT     = 4;
    localparam int STARVE_LIMIT_DEFAULT = 15;

    // Same word and at least one shared byte lane.
    function automatic logic req_overlap(input sb_entry_t entry, input logic [31:0] paddr,
                                         input logic [3:0] byteenable);
        return (entry.paddr[31:2] == paddr[31:2]) && ((entry.byteenable & byteenable) != 4'b0000);
    endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - in-order committed-store FIFO with parallel load-overlap compare
module store_buffer_fifo
    import dbus_store_arbiter_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  sb_entry_t                  push_data,
    input  logic                       pop,
    output sb_entry_t                  head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    input  logic [31:0]                ld_paddr,
    input  logic [3:0]                 ld_byteenable,
    output logic                       conflict
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t         mem [DEPTH];
    logic [PW-1:0]     head_ptr;
    logic [PW-1:0]     tail_ptr;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic              full_q;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok  = push & ~full_q;
    assign pop_ok   = pop & (cnt != '0);
    assign cnt_next = cnt + CW'(push_ok) - CW'(pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            cnt      <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push_ok) tail_ptr <= tail_ptr + 1'b1;
            if (pop_ok)  head_ptr <= head_ptr + 1'b1;
            cnt    <= cnt_next;
            full_q <= (cnt_next == CW'(DEPTH));
        end
    end

    // Payload storage needs no reset; validity comes from the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[tail_ptr] <= push_data;
    end

    // An entry is live when its distance from head is below count.
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(PW'(PW'(i) - head_ptr)) < cnt) && req_overlap(mem[i], ld_paddr, ld_byteenable))
                conflict = 1'b1;
        end
    end

    assign head  = mem[head_ptr];
    assign count = cnt;
    assign full  = full_q;
    assign empty = (cnt == '0);

endmodule

// File: rtl/dbus_store_arbiter.sv
// rtl/dbus_store_arbiter.sv - shares the dbus request channel between LSU loads and buffered stores
module dbus_store_arbiter
    import dbus_store_arbiter_pkg::*;
#(
    parameter int SB_DEPTH     = SB_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          st_push,
    input  data_memreq_t  st_req,
    output logic          st_full,
    output logic          sb_empty,
    input  logic          ld_request,
    input  data_memreq_t  ld_req,
    output logic          ld_ready,
    output logic          dbus_request,
    output data_memreq_t  dbus_req,
    input  logic          dbus_ready
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, HOLD_LD, HOLD_ST} state_t;

    state_t                    state;
    state_t                    next_state;
    sb_entry_t                 head;
    logic [$clog2(SB_DEPTH):0] count;
    logic                      fifo_empty;
    logic                      conflict;
    logic                      sel_ld;
    logic                      sel_st;
    logic                      pop;
    logic                      ld_eligible;
    logic [SW-1:0]             starve_cnt;
    data_memreq_t              ld_hold;
    data_memreq_t              st_out;

    store_buffer_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
        .clk           (clk),
        .rst           (rst),
        .push          (st_push),
        .push_data     (st_req),
        .pop           (pop),
        .head          (head),
        .count         (count),
        .full          (st_full),
        .empty         (fifo_empty),
        .ld_paddr      (ld_req.paddr),
        .ld_byteenable (ld_req.byteenable),
        .conflict      (conflict)
    );

    assign ld_eligible = ld_request & ~flush & ~conflict & ~st_full
                       & (~ld_req.uncached | fifo_empty)
                       & (starve_cnt < SW'(STARVE_LIMIT));

    always_comb begin
        next_state = state;
        sel_ld     = 1'b0;
        sel_st     = 1'b0;
        unique case (state)
            IDLE: begin
                if (ld_eligible) begin
                    sel_ld = 1'b1;
                    if (!dbus_ready) next_state = HOLD_LD;
                end else if (!fifo_empty) begin
                    sel_st = 1'b1;
                    if (!dbus_ready) next_state = HOLD_ST;
                end
            end
            HOLD_LD: begin
                sel_ld = 1'b1;
                if (dbus_ready) next_state = IDLE;
            end
            HOLD_ST: begin
                sel_st = 1'b1;
                if (dbus_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        st_out       = head;
        st_out.write = 1'b1;
        st_out.read  = 1'b0;
        dbus_req     = '0;
        if (sel_ld)      dbus_req = (state == HOLD_LD) ? ld_hold : ld_req;
        else if (sel_st) dbus_req = st_out;
    end

    assign dbus_request = sel_ld | sel_st;
    assign ld_ready     = dbus_ready & sel_ld & ~flush;
    assign pop          = dbus_ready & sel_st;
    assign sb_empty     = fifo_empty & (state != HOLD_ST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            ld_hold    <= '0;
        end else begin
            state <= next_state;
            // A stalled load grant keeps its original payload even if the LSU side moves.
            if (state == IDLE && sel_ld) ld_hold <= ld_req;
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (state == IDLE && sel_ld && starve_cnt < SW'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dbus_store_arbiter.sv
// tb/tb_dbus_store_arbiter.sv - directed self-checking bench for dbus_store_arbiter
module tb_dbus_store_arbiter;
    import dbus_store_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         st_push;
    data_memreq_t st_req;
    logic         st_full;
    logic         sb_empty;
    logic         ld_request;
    data_memreq_t ld_req;
    logic         ld_ready;
    logic         dbus_request;
    data_memreq_t dbus_req;
    logic         dbus_ready;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    dbus_store_arbiter #(.SB_DEPTH(4), .STARVE_LIMIT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .st_push      (st_push),
        .st_req       (st_req),
        .st_full      (st_full),
        .sb_empty     (sb_empty),
        .ld_request   (ld_request),
        .ld_req       (ld_req),
        .ld_ready     (ld_ready),
        .dbus_request (dbus_request),
        .dbus_req     (dbus_req),
        .dbus_ready   (dbus_ready)
    );

    function automatic data_memreq_t mk(input logic rd, input logic unc, input logic [3:0] be,
                                        input logic [31:0] pa, input logic [31:0] wd);
        data_memreq_t r;
        r.read       = rd;
        r.write      = ~rd;
        r.uncached   = unc;
        r.byteenable = be;
        r.paddr      = pa;
        r.wrdata     = wd;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 0; st_push = 0; st_req = '0; ld_request = 0; ld_req = '0; dbus_ready = 0;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (dbus_request !== 1'b0) begin failed++; $display("FAIL reset_dbus_request got %b exp 0", dbus_request); end
        tests++; if (dbus_req !== '0) begin failed++; $display("FAIL reset_dbus_req got %h exp 0", dbus_req); end
        tests++; if (ld_ready !== 1'b0) begin failed++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
        tests++; if (st_full !== 1'b0) begin failed++; $display("FAIL reset_st_full got %b exp 0", st_full); end
        tests++; if (sb_empty !== 1'b1) begin failed++; $display("FAIL reset_sb_empty got %b exp 1", sb_empty); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_load_fast();
        data_memreq_t l;
        l = mk(1, 0, 4'hf, 32'h0000_1000, 32'h0);
        ld_request = 1; ld_req = l; dbus_ready = 1;
        #1;
        tests++; if (dbus_request !== 1'b1) begin failed++; $display("FAIL fast_dbus_request got %b exp 1", dbus_request); end
        tests++; if (ld_ready !== 1'b1) begin failed++; $display("FAIL fast_ld_ready got %b exp 1", ld_ready); end
        tests++; if (dbus_req !== l) begin failed++; $display("FAIL fast_payload got %h exp %h", dbus_req, l); end
        tests++; if (sb_empty !== 1'b1) begin failed++; $display("FAIL fast_sb_empty got %b exp 1", sb_empty); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_ordering();
        st_push = 1; st_req = mk(0, 0, 4'b0011, 32'h0000_2004, 32'hAAAA_5555);
        #1;
        tests++; if (dbus_request !== 1'b0) begin failed++; $display("FAIL ord_push_visible got %b exp 0", dbus_request); end
        cyc();
        st_push = 0; st_req = '0;
        ld_request = 1; ld_req = mk(1, 0, 4'b0010, 32'h0000_2004, 32'h0); dbus_ready = 1;
        #1;
        tests++; if (dbus_req.write !== 1'b1 || dbus_req.paddr !== 32'h2004 || dbus_req.wrdata !== 32'hAAAA_5555)
            begin failed++; $display("FAIL ord_store_first got %h exp write 2004", dbus_req); end
        tests++; if (ld_ready !== 1'b0) begin failed++; $display("FAIL ord_ld_wait got %b exp 0", ld_ready); end
        cyc();
        #1;
        tests++; if (ld_ready !== 1'b1 || dbus_req.read !== 1'b1) begin failed++; $display("FAIL ord_ld_after got rdy %b req %h exp rdy 1 read", ld_ready, dbus_req); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            st_push = 1; st_req = mk(0, 0, 4'hf, 32'h0000_8000 + 32'(i * 4), 32'h100 + 32'(i));
            cyc();
        end
        #1;
        tests++; if (st_full !== 1'b1) begin failed++; $display("FAIL fill_full got %b exp 1", st_full); end
        st_req = mk(0, 0, 4'hf, 32'h0000_9000, 32'hdead);
        cyc();
        st_push = 0; st_req = '0;
        #1;
        tests++; if (st_full !== 1'b1) begin failed++; $display("FAIL fill_5th_full got %b exp 1", st_full); end
        tests++; if (sb_empty !== 1'b0) begin failed++; $display("FAIL fill_sb_empty got %b exp 0", sb_empty); end
        dbus_ready = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++; if (dbus_request !== 1'b1 || dbus_req.paddr !== 32'h0000_8000 + 32'(i * 4) || dbus_req.wrdata !== 32'h100 + 32'(i))
                begin failed++; $display("FAIL fill_pop%0d got %b %h exp addr %h", i, dbus_request, dbus_req.paddr, 32'h8000 + 32'(i * 4)); end
            cyc();
        end
        #1;
        tests++; if (dbus_request !== 1'b0) begin failed++; $display("FAIL fill_no_5th got %b exp 0", dbus_request); end
        tests++; if (sb_empty !== 1'b1 || st_full !== 1'b0) begin failed++; $display("FAIL fill_drained got empty %b full %b exp 1 0", sb_empty, st_full); end
        idle_inputs();
    endtask

    task automatic test_starve();
        st_push = 1; st_req = mk(0, 0, 4'hf, 32'h0000_3000, 32'h3333); dbus_ready = 1;
        cyc();
        st_push = 0; st_req = '0;
        ld_request = 1; ld_req = mk(1, 0, 4'hf, 32'h0000_4000, 32'h0);
        for (int i = 0; i < 15; i++) begin
            #1;
            tests++; if (ld_ready !== 1'b1) begin failed++; $display("FAIL starve_ld%0d got %b exp 1", i, ld_ready); end
            cyc();
        end
        #1;
        tests++; if (ld_ready !== 1'b0 || dbus_req.write !== 1'b1 || dbus_req.paddr !== 32'h3000)
            begin failed++; $display("FAIL starve_store_wins got rdy %b req %h exp store 3000", ld_ready, dbus_req); end
        cyc();
        #1;
        tests++; if (ld_ready !== 1'b1) begin failed++; $display("FAIL starve_reset got %b exp 1", ld_ready); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_uncached();
        st_push = 1; st_req = mk(0, 0, 4'hf, 32'h0000_6000, 32'h60);
        cyc();
        st_req = mk(0, 0, 4'hf, 32'h0000_6004, 32'h64);
        cyc();
        st_push = 0; st_req = '0;
        ld_request = 1; ld_req = mk(1, 1, 4'hf, 32'h0000_5000, 32'h0); dbus_ready = 1;
        #1;
        tests++; if (ld_ready !== 1'b0 || dbus_req.paddr !== 32'h6000) begin failed++; $display("FAIL unc_first got rdy %b addr %h exp 0 6000", ld_ready, dbus_req.paddr); end
        cyc();
        #1;
        tests++; if (ld_ready !== 1'b0 || dbus_req.paddr !== 32'h6004) begin failed++; $display("FAIL unc_second got rdy %b addr %h exp 0 6004", ld_ready, dbus_req.paddr); end
        cyc();
        #1;
        tests++; if (ld_ready !== 1'b1 || dbus_req.uncached !== 1'b1 || dbus_req.paddr !== 32'h5000)
            begin failed++; $display("FAIL unc_issue got rdy %b req %h exp 1 5000", ld_ready, dbus_req); end
        cyc();
        idle_inputs();
    endtask

    task automatic test_flush_and_reset();
        ld_request = 1; ld_req = mk(1, 0, 4'hf, 32'h0000_7000, 32'h0); dbus_ready = 0;
        #1;
        tests++; if (dbus_request !== 1'b1 || ld_ready !== 1'b0) begin failed++; $display("FAIL flush_grant got %b %b exp 1 0", dbus_request, ld_ready); end
        cyc();
        flush = 1;
        #1;
        tests++; if (dbus_request !== 1'b1 || dbus_req.paddr !== 32'h7000) begin failed++; $display("FAIL flush_hold got %b %h exp 1 7000", dbus_request, dbus_req.paddr); end
        cyc();
        dbus_ready = 1;
        #1;
        tests++; if (dbus_request !== 1'b1 || ld_ready !== 1'b0) begin failed++; $display("FAIL flush_done got %b %b exp 1 0", dbus_request, ld_ready); end
        cyc();
        idle_inputs();
        #1;
        tests++; if (dbus_request !== 1'b0) begin failed++; $display("FAIL flush_idle got %b exp 0", dbus_request); end
        st_push = 1; st_req = mk(0, 0, 4'hf, 32'h0000_a000, 32'ha);
        cyc();
        st_push = 0; st_req = '0;
        cyc();
        #1;
        tests++; if (sb_empty !== 1'b0 || dbus_request !== 1'b1) begin failed++; $display("FAIL hold_st got empty %b req %b exp 0 1", sb_empty, dbus_request); end
        #1 rst = 1;
        #1;
        tests++; if (dbus_request !== 1'b0 || dbus_req !== '0 || ld_ready !== 1'b0 || st_full !== 1'b0 || sb_empty !== 1'b1)
            begin failed++; $display("FAIL async_reset got req %b pay %h rdy %b full %b empty %b", dbus_request, dbus_req, ld_ready, st_full, sb_empty); end
        @(negedge clk);
        rst = 0;
        cyc();
        #1;
        tests++; if (dbus_request !== 1'b0 || sb_empty !== 1'b1) begin failed++; $display("FAIL post_reset got %b %b exp 0 1", dbus_request, sb_empty); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        test_reset();
        test_load_fast();
        test_ordering();
        test_fill();
        test_starve();
        test_uncached();
        test_flush_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
